// File: rtl/sub_result_checker.sv
// sub_result_checker: streaming self-check for the subtract path.
// Each accepted (minuend, subtrahend, result) triple is checked by the inverse
// operation: result + subtrahend (mod 2^WIDTH) must equal the minuend.
// Keeps saturating pass/fail counters and a sticky error flag. With
// STOP_ON_FAIL=1 intake halts on the first counted mismatch.
// Optional feature macro: SUB_CHK_CAPTURE_EN. When defined, the first failing
// triple after reset or cnt_clr is held on the first_fail_* outputs.
//
// Handshake: a triple transfers on a rising edge where chk_valid and chk_ready
// are both 1. chk_ready is a registered function of the FSM state only and
// never depends on chk_valid. The source holds its triple until it transfers.
module sub_result_checker #(
    parameter int WIDTH        = 32,
    parameter int CNT_W        = 16,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_valid,
    output logic             chk_ready,
    input  logic [WIDTH-1:0] chk_in1,
    input  logic [WIDTH-1:0] chk_in2,
    input  logic [WIDTH-1:0] chk_out,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_sticky,
    output logic             busy,
    output logic             halted
`ifdef SUB_CHK_CAPTURE_EN
    ,
    output logic [WIDTH-1:0] first_fail_in1,
    output logic [WIDTH-1:0] first_fail_in2,
    output logic [WIDTH-1:0] first_fail_out,
    output logic             first_fail_valid
`endif
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_in1;
    logic [WIDTH-1:0] s1_in2;
    logic [WIDTH-1:0] s1_out;

    logic             accept;
    logic [WIDTH-1:0] sum;
    logic             match;
    logic             mismatch_now;

    // Carry out of the add is discarded: the check is modulo 2^WIDTH.
    assign accept       = chk_valid & chk_ready;
    assign sum          = s1_out + s1_in2;
    assign match        = (sum == s1_in1);
    assign mismatch_now = s1_valid & ~match;
    assign busy         = s1_valid;

    // Stage 1: capture the transferred triple; valid bit marks it unchecked.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_in1   <= '0;
            s1_in2   <= '0;
            s1_out   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_in1 <= chk_in1;
                s1_in2 <= chk_in2;
                s1_out <= chk_out;
            end
        end
    end

    // Run/halt FSM with registered chk_ready and halted; only rst leaves HALT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            chk_ready <= 1'b1;
            halted    <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if ((STOP_ON_FAIL != 0) && mismatch_now) begin
                        state     <= ST_HALT;
                        chk_ready <= 1'b0;
                        halted    <= 1'b1;
                    end
                end
                ST_HALT: begin
                    state     <= ST_HALT;
                    chk_ready <= 1'b0;
                    halted    <= 1'b1;
                end
                default: begin
                    state     <= ST_RUN;
                    chk_ready <= 1'b1;
                    halted    <= 1'b0;
                end
            endcase
        end
    end

    // Stage 2: count the stage-1 verdict; cnt_clr wins over a landing count.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            err_sticky <= 1'b0;
        end else if (s1_valid) begin
            if (match) begin
                if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_ONE;
            end else begin
                if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_ONE;
                err_sticky <= 1'b1;
            end
        end
    end

`ifdef SUB_CHK_CAPTURE_EN
    // Hold the first failing triple until rst or cnt_clr.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            first_fail_in1   <= '0;
            first_fail_in2   <= '0;
            first_fail_out   <= '0;
            first_fail_valid <= 1'b0;
        end else if (mismatch_now && !first_fail_valid) begin
            first_fail_in1   <= s1_in1;
            first_fail_in2   <= s1_in2;
            first_fail_out   <= s1_out;
            first_fail_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sub_result_checker.sv
// Bench for sub_result_checker: three instances (default, 4-bit counters,
// stop-on-fail) sharing the triple buses, each with its own valid/rst/cnt_clr.
module tb_sub_result_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] in1 = '0, in2 = '0, out = '0;

  // default instance
  logic d_rst = 1'b1, d_valid = 1'b0, d_clr = 1'b0;
  logic d_ready, d_err, d_busy, d_halted;
  logic [15:0] d_pass, d_fail;
  // saturation instance (CNT_W = 4)
  logic s_rst = 1'b1, s_valid = 1'b0, s_clr = 1'b0;
  logic s_ready, s_err, s_busy, s_halted;
  logic [3:0] s_pass, s_fail;
  // stop-on-fail instance
  logic h_rst = 1'b1, h_valid = 1'b0, h_clr = 1'b0;
  logic h_ready, h_err, h_busy, h_halted;
  logic [15:0] h_pass, h_fail;
`ifdef SUB_CHK_CAPTURE_EN
  logic [31:0] d_ff1, d_ff2, d_ffo, s_ff1, s_ff2, s_ffo, h_ff1, h_ff2, h_ffo;
  logic d_ffv, s_ffv, h_ffv;
`endif

  sub_result_checker #(.WIDTH(32), .CNT_W(16), .STOP_ON_FAIL(0)) dut (
    .clk(clk), .rst(d_rst), .chk_valid(d_valid), .chk_ready(d_ready),
    .chk_in1(in1), .chk_in2(in2), .chk_out(out), .cnt_clr(d_clr),
    .pass_cnt(d_pass), .fail_cnt(d_fail), .err_sticky(d_err),
    .busy(d_busy), .halted(d_halted)
`ifdef SUB_CHK_CAPTURE_EN
    , .first_fail_in1(d_ff1), .first_fail_in2(d_ff2), .first_fail_out(d_ffo),
    .first_fail_valid(d_ffv)
`endif
  );

  sub_result_checker #(.WIDTH(32), .CNT_W(4), .STOP_ON_FAIL(0)) dut_sat (
    .clk(clk), .rst(s_rst), .chk_valid(s_valid), .chk_ready(s_ready),
    .chk_in1(in1), .chk_in2(in2), .chk_out(out), .cnt_clr(s_clr),
    .pass_cnt(s_pass), .fail_cnt(s_fail), .err_sticky(s_err),
    .busy(s_busy), .halted(s_halted)
`ifdef SUB_CHK_CAPTURE_EN
    , .first_fail_in1(s_ff1), .first_fail_in2(s_ff2), .first_fail_out(s_ffo),
    .first_fail_valid(s_ffv)
`endif
  );

  sub_result_checker #(.WIDTH(32), .CNT_W(16), .STOP_ON_FAIL(1)) dut_halt (
    .clk(clk), .rst(h_rst), .chk_valid(h_valid), .chk_ready(h_ready),
    .chk_in1(in1), .chk_in2(in2), .chk_out(out), .cnt_clr(h_clr),
    .pass_cnt(h_pass), .fail_cnt(h_fail), .err_sticky(h_err),
    .busy(h_busy), .halted(h_halted)
`ifdef SUB_CHK_CAPTURE_EN
    , .first_fail_in1(h_ff1), .first_fail_in2(h_ff2), .first_fail_out(h_ffo),
    .first_fail_valid(h_ffv)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference scoreboard for the default instance: triples waiting to land.
  logic [31:0] exp_q1[$], exp_q2[$], exp_qo[$];
  int unsigned m_pass = 0, m_fail = 0;
  logic m_err = 1'b0;
  logic m_cap_v = 1'b0;
  logic [31:0] m_cap1 = '0, m_cap2 = '0, m_capo = '0;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_triple(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    in1 = a; in2 = b; out = c;
  endtask

  // Spec rule stated arithmetically: (result + subtrahend) mod 2^32 == minuend.
  function automatic bit is_good(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    longint unsigned s;
    s = (longint'(c) + longint'(b)) % 64'h1_0000_0000;
    return s == longint'(a);
  endfunction

  task automatic test_reset();
    d_rst = 1; s_rst = 1; h_rst = 1;
    cycle(); cycle();
    d_rst = 0; s_rst = 0; h_rst = 0;
    n_checks++;
    if (d_pass !== 16'd0 || d_fail !== 16'd0 || d_err !== 1'b0 || d_busy !== 1'b0 ||
        d_halted !== 1'b0 || d_ready !== 1'b1) begin
      $display("FAIL reset_default: pass=%0d fail=%0d err=%b busy=%b halted=%b ready=%b, want 0 0 0 0 0 1",
               d_pass, d_fail, d_err, d_busy, d_halted, d_ready);
      n_fail++;
    end
    n_checks++;
    if (h_halted !== 1'b0 || h_ready !== 1'b1 || s_pass !== 4'd0 || s_ready !== 1'b1) begin
      $display("FAIL reset_others: h_halted=%b h_ready=%b s_pass=%0d s_ready=%b, want 0 1 0 1",
               h_halted, h_ready, s_pass, s_ready);
      n_fail++;
    end
`ifdef SUB_CHK_CAPTURE_EN
    n_checks++;
    if (d_ffv !== 1'b0 || d_ff1 !== 32'd0 || d_ff2 !== 32'd0 || d_ffo !== 32'd0) begin
      $display("FAIL reset_capture: v=%b %h %h %h, want all 0", d_ffv, d_ff1, d_ff2, d_ffo);
      n_fail++;
    end
`endif
  endtask

  task automatic test_single_pass();
    set_triple(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE);
    d_valid = 1;
    cycle();                     // edge N
    d_valid = 0;
    n_checks++;
    if (d_busy !== 1'b1 || d_pass !== 16'd0) begin
      $display("FAIL single_after_N: busy=%b pass=%0d, want 1 0", d_busy, d_pass);
      n_fail++;
    end
    cycle();                     // edge N+1
    n_checks++;
    if (d_pass !== 16'd1 || d_fail !== 16'd0 || d_err !== 1'b0 || d_busy !== 1'b0) begin
      $display("FAIL single_after_N1: pass=%0d fail=%0d err=%b busy=%b, want 1 0 0 0",
               d_pass, d_fail, d_err, d_busy);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta[4], tb[4], tc[4];
    ta[0] = 32'd0;          tb[0] = 32'd12345678; tc[0] = 32'hFF43_9EB2;
    ta[1] = 32'd6;          tb[1] = 32'd9;        tc[1] = 32'hFFFF_FFFD;
    ta[2] = 32'd555;        tb[2] = 32'd246;      tc[2] = 32'd309;
    ta[3] = 32'hFFFF_FFFF;  tb[3] = 32'd2;        tc[3] = 32'hFFFF_FFFD;
    d_valid = 1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) set_triple(ta[i], tb[i], tc[i]);
      else d_valid = 0;
      cycle();
      // pass count started at 1; the triple transferred at loop i lands one edge later
      n_checks++;
      if (d_pass !== 16'(1 + i) || d_busy !== (i < 4)) begin
        $display("FAIL b2b_step%0d: pass=%0d busy=%b, want %0d %b", i, d_pass, d_busy, 1 + i, i < 4);
        n_fail++;
      end
    end
    cycle();
    n_checks++;
    if (d_pass !== 16'd5 || d_fail !== 16'd0 || d_busy !== 1'b0) begin
      $display("FAIL b2b_final: pass=%0d fail=%0d busy=%b, want 5 0 0", d_pass, d_fail, d_busy);
      n_fail++;
    end
  endtask

  task automatic test_mismatch();
    set_triple(32'd555, 32'd246, 32'd310);
    d_valid = 1;
    cycle();
    set_triple(32'd6, 32'd9, 32'd0);
    cycle();                     // first mismatch lands, second accepted
    d_valid = 0;
    n_checks++;
    if (d_fail !== 16'd1 || d_err !== 1'b1 || d_pass !== 16'd5) begin
      $display("FAIL mismatch_first: fail=%0d err=%b pass=%0d, want 1 1 5", d_fail, d_err, d_pass);
      n_fail++;
    end
`ifdef SUB_CHK_CAPTURE_EN
    n_checks++;
    if (d_ffv !== 1'b1 || d_ff1 !== 32'd555 || d_ff2 !== 32'd246 || d_ffo !== 32'd310) begin
      $display("FAIL capture_first: v=%b %0d %0d %0d, want 1 555 246 310", d_ffv, d_ff1, d_ff2, d_ffo);
      n_fail++;
    end
`endif
    cycle();
    n_checks++;
    if (d_fail !== 16'd2 || d_err !== 1'b1 || d_halted !== 1'b0 || d_ready !== 1'b1) begin
      $display("FAIL mismatch_second: fail=%0d err=%b halted=%b ready=%b, want 2 1 0 1",
               d_fail, d_err, d_halted, d_ready);
      n_fail++;
    end
`ifdef SUB_CHK_CAPTURE_EN
    n_checks++;
    if (d_ffv !== 1'b1 || d_ff1 !== 32'd555 || d_ff2 !== 32'd246 || d_ffo !== 32'd310) begin
      $display("FAIL capture_kept: v=%b %0d %0d %0d, want 1 555 246 310", d_ffv, d_ff1, d_ff2, d_ffo);
      n_fail++;
    end
`endif
  endtask

  task automatic test_clr_same_edge();
    set_triple(32'd555, 32'd246, 32'd309);
    d_valid = 1;
    cycle();                     // edge N: passing triple accepted
    d_valid = 0;
    d_clr = 1;
    cycle();                     // edge N+1: result lands together with clear
    d_clr = 0;
    n_checks++;
    if (d_pass !== 16'd0 || d_fail !== 16'd0 || d_err !== 1'b0) begin
      $display("FAIL clr_same_edge: pass=%0d fail=%0d err=%b, want 0 0 0", d_pass, d_fail, d_err);
      n_fail++;
    end
    cycle();
    n_checks++;
    if (d_pass !== 16'd0 || d_busy !== 1'b0) begin
      $display("FAIL clr_dropped: pass=%0d busy=%b, want 0 0", d_pass, d_busy);
      n_fail++;
    end
`ifdef SUB_CHK_CAPTURE_EN
    n_checks++;
    if (d_ffv !== 1'b0 || d_ff1 !== 32'd0) begin
      $display("FAIL clr_capture: v=%b in1=%0d, want 0 0", d_ffv, d_ff1);
      n_fail++;
    end
`endif
  endtask

  task automatic test_saturation();
    logic [31:0] a, b;
    s_valid = 1;
    for (int i = 0; i < 20; i++) begin
      a = $urandom; b = $urandom;
      set_triple(a, b, a - b);
      cycle();
    end
    s_valid = 0;
    cycle();
    n_checks++;
    if (s_pass !== 4'd15 || s_fail !== 4'd0 || s_err !== 1'b0) begin
      $display("FAIL saturation: pass=%0d fail=%0d err=%b, want 15 0 0", s_pass, s_fail, s_err);
      n_fail++;
    end
  endtask

  task automatic test_halt();
    set_triple(32'd555, 32'd246, 32'd310);
    h_valid = 1;
    cycle();                     // edge N: failing triple
    set_triple(32'd555, 32'd246, 32'd309);
    n_checks++;
    if (h_ready !== 1'b1 || h_halted !== 1'b0) begin
      $display("FAIL halt_before: ready=%b halted=%b, want 1 0", h_ready, h_halted);
      n_fail++;
    end
    cycle();                     // edge N+1: mismatch counted, passing triple accepted
    n_checks++;
    if (h_halted !== 1'b1 || h_ready !== 1'b0 || h_fail !== 16'd1 || h_pass !== 16'd0 || h_busy !== 1'b1) begin
      $display("FAIL halt_enter: halted=%b ready=%b fail=%0d pass=%0d busy=%b, want 1 0 1 0 1",
               h_halted, h_ready, h_fail, h_pass, h_busy);
      n_fail++;
    end
    cycle();                     // edge N+2: drained triple counted
    n_checks++;
    if (h_pass !== 16'd1 || h_busy !== 1'b0) begin
      $display("FAIL halt_drain: pass=%0d busy=%b, want 1 0", h_pass, h_busy);
      n_fail++;
    end
    for (int i = 0; i < 4; i++) cycle();
    n_checks++;
    if (h_pass !== 16'd1 || h_fail !== 16'd1 || h_busy !== 1'b0 || h_ready !== 1'b0) begin
      $display("FAIL halt_no_intake: pass=%0d fail=%0d busy=%b ready=%b, want 1 1 0 0",
               h_pass, h_fail, h_busy, h_ready);
      n_fail++;
    end
    h_clr = 1;
    cycle();
    h_clr = 0;
    n_checks++;
    if (h_halted !== 1'b1 || h_pass !== 16'd0 || h_fail !== 16'd0 || h_err !== 1'b0) begin
      $display("FAIL halt_clr: halted=%b pass=%0d fail=%0d err=%b, want 1 0 0 0",
               h_halted, h_pass, h_fail, h_err);
      n_fail++;
    end
    h_valid = 0;
    h_rst = 1;
    cycle();
    h_rst = 0;
    n_checks++;
    if (h_halted !== 1'b0 || h_ready !== 1'b1) begin
      $display("FAIL halt_rst: halted=%b ready=%b, want 0 1", h_halted, h_ready);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    set_triple(32'd6, 32'd9, 32'hFFFF_FFFD);
    d_valid = 1;
    cycle();                     // edge N: transfer
    d_valid = 0;
    d_rst = 1;
    cycle();                     // edge N+1: reset discards it
    d_rst = 0;
    n_checks++;
    if (d_pass !== 16'd0 || d_busy !== 1'b0 || d_ready !== 1'b1) begin
      $display("FAIL reset_mid: pass=%0d busy=%b ready=%b, want 0 0 1", d_pass, d_busy, d_ready);
      n_fail++;
    end
    cycle();
    n_checks++;
    if (d_pass !== 16'd0 || d_fail !== 16'd0) begin
      $display("FAIL reset_mid_after: pass=%0d fail=%0d, want 0 0", d_pass, d_fail);
      n_fail++;
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, c, p1, p2, po;
    logic clr_now, xfer_now;
    exp_q1.delete(); exp_q2.delete(); exp_qo.delete();
    m_pass = 0; m_fail = 0; m_err = 0; m_cap_v = 0;
    m_cap1 = '0; m_cap2 = '0; m_capo = '0;
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      c = ($urandom_range(0, 1) == 0) ? (a - b) : $urandom;
      set_triple(a, b, c);
      xfer_now = ($urandom_range(0, 3) != 0);
      clr_now  = ($urandom_range(0, 19) == 0);
      d_valid = xfer_now;
      d_clr   = clr_now;
      cycle();
      if (exp_q1.size() != 0) begin
        p1 = exp_q1.pop_front(); p2 = exp_q2.pop_front(); po = exp_qo.pop_front();
        if (!clr_now) begin
          if (is_good(p1, p2, po)) begin
            if (m_pass < 65535) m_pass++;
          end else begin
            if (m_fail < 65535) m_fail++;
            m_err = 1;
            if (!m_cap_v) begin
              m_cap_v = 1; m_cap1 = p1; m_cap2 = p2; m_capo = po;
            end
          end
        end
      end
      if (clr_now) begin
        m_pass = 0; m_fail = 0; m_err = 0;
        m_cap_v = 0; m_cap1 = '0; m_cap2 = '0; m_capo = '0;
      end
      if (xfer_now) begin
        exp_q1.push_back(a); exp_q2.push_back(b); exp_qo.push_back(c);
      end
      n_checks++;
      if (d_pass !== 16'(m_pass) || d_fail !== 16'(m_fail) || d_err !== m_err ||
          d_busy !== xfer_now || d_ready !== 1'b1) begin
        $display("FAIL random_cyc%0d: pass=%0d fail=%0d err=%b busy=%b ready=%b, want %0d %0d %b %b 1",
                 i, d_pass, d_fail, d_err, d_busy, d_ready, m_pass, m_fail, m_err, xfer_now);
        n_fail++;
      end
`ifdef SUB_CHK_CAPTURE_EN
      n_checks++;
      if (d_ffv !== m_cap_v || d_ff1 !== m_cap1 || d_ff2 !== m_cap2 || d_ffo !== m_capo) begin
        $display("FAIL random_cap_cyc%0d: v=%b %h %h %h, want %b %h %h %h",
                 i, d_ffv, d_ff1, d_ff2, d_ffo, m_cap_v, m_cap1, m_cap2, m_capo);
        n_fail++;
      end
`endif
    end
    d_valid = 0;
    d_clr = 0;
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_back_to_back();
    test_mismatch();
    test_clr_same_edge();
    test_saturation();
    test_halt();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
